ro_count_reader: RTL and testbench
==================================

Name: ro_count_reader

Overview:
- Measurement sequencer on the reading side of the ring-oscillator edge counter (n-bit up-counter with async active-low clear).
- Clears the counter, opens a gate window of fixed length, then freezes the counter and waits for it to settle.
- Samples the count until two consecutive samples are stable, and presents the result on a valid/ready handshake.
- Sits between the counter and the readout/host logic in the system clock domain.

Parameters:
- N, 16, counter/result width; matches the counter's n+1 bits.
- GATE_CYCLES, 1000, gate window length in clk cycles; legal range 1..2^GATE_W-1.
- GATE_W, 16, width of the gate timer.
- CLR_CYCLES, 2, number of cycles cnt_rst_n is held low; minimum 1.
- SETTLE_CYCLES, 4, wait after the gate closes before the first sample; minimum 1.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, reset; asynchronous, active-low.
- start, input, 1, one-cycle request to begin a measurement; only honoured in IDLE.
- cnt_rst_n, output, 1, active-low clear driven to the counter.
- cnt_en, output, 1, counter gate enable; high only during GATE.
- count_in, input, N, counter value; asynchronous to clk, may toggle.
- result, output, N, captured count.
- overflow, output, 1, set if the counter wrapped during the gate.
- result_valid, output, 1, result/overflow are valid.
- result_ready, input, 1, consumer accepts the result.
- busy, output, 1, high in every state except IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; cnt_rst_n=0; cnt_en=0; result=0; overflow=0; result_valid=0; busy=0; all timers 0.
  - cnt_rst_n is 0 during reset and rises on the first clk edge after reset release.
- FSM, all outputs registered:
  - IDLE: cnt_rst_n=1, cnt_en=0. start=1 -> CLEAR, clear timer, clear overflow. start is ignored in all other states.
  - CLEAR: cnt_rst_n=0 for exactly CLR_CYCLES cycles -> GATE.
  - GATE: cnt_en=1, cnt_rst_n=1. The gate timer counts 0..GATE_CYCLES-1, so cnt_en is high for exactly GATE_CYCLES cycles -> SETTLE.
  - SETTLE: cnt_en=0 for exactly SETTLE_CYCLES cycles -> SAMPLE.
  - SAMPLE:
    - Register count_in into s0; next cycle register count_in into s1 and compare s0 with s1.
    - Equal -> result<=s1, go to HOLD.
    - Not equal -> shift (s0<=s1) and resample every cycle; there is no retry limit.
  - HOLD: result_valid=1; result and overflow are stable.
    - result_valid & result_ready in the same cycle -> IDLE, result_valid=0 next cycle.
    - result and overflow keep their values after the handshake until the next CLEAR.
- Overflow detection:
  - During GATE, register msb_prev <= count_in[N-1].
  - msb_prev=1 and count_in[N-1]=0 -> overflow<=1.
  - overflow is sticky until the next CLEAR.
  - It is evaluated only in GATE, not on the first GATE cycle (msb_prev starts at 0 on entry to GATE).
- Latency: from the start cycle to result_valid = 1 + CLR_CYCLES + GATE_CYCLES + SETTLE_CYCLES + 2 cycles, with a stable count_in.
- Boundary conditions:
  - start asserted in HOLD with result_ready=1: the handshake completes; start is ignored and must be re-asserted in IDLE.
  - result_ready held high continuously: result_valid pulses for exactly 1 cycle.
  - rst_n asserted mid-measurement: immediate return to the reset values; no partial result and no valid.
  - count_in all-ones at sample time with no wrap: result=2^N-1, overflow=0.
- Arithmetic:
  - Timers are unsigned and do not wrap; the gate timer width must hold GATE_CYCLES-1.
  - Result is the raw count; there is no scaling.

Test Plan:
- Reset check: rst_n=0 then release, stimulus idle -> cnt_rst_n=0, cnt_en=0, result=0, valid=0, busy=0; after 1 clk, cnt_rst_n=1.
- Nominal measurement: GATE_CYCLES=10, CLR_CYCLES=2, SETTLE_CYCLES=4; model counter increments every cycle while cnt_en=1; pulse start, result_ready=1.
  - Required: cnt_rst_n low exactly 2 cycles; cnt_en high exactly 10 cycles.
  - Required: result=10, overflow=0, result_valid at cycle 1+2+10+4+2=19 after start.
- Back-pressure: result_ready=0 for 20 cycles after valid -> result_valid held, result stable; ready=1 -> valid drops next cycle; busy=0.
- Unstable sample: count_in toggles 0x0005/0x0006 for 3 sample cycles, then holds at 0x0006 -> result=0x0006, valid only after two equal samples.
- Overflow: N=4, counter starts at 14, gate 5 cycles (14,15,0,1,2) -> overflow=1, result=3; next measurement with no wrap -> overflow=0.
- Reset mid-GATE, and start ignored while busy:
  - rst_n low in GATE cycle 3 -> outputs at reset values immediately.
  - New start -> full sequence from CLEAR.
  - start re-pulsed during GATE -> no restart; timer unaffected.

Source files
------------

// File: rtl/ro_count_reader.sv
// Measurement sequencer for a ring-oscillator edge counter: clear, gate, settle,
// sample until two consecutive reads agree, then hand the count over valid/ready.
module ro_count_reader #(
    parameter int N             = 16,
    parameter int GATE_CYCLES   = 1000,
    parameter int GATE_W        = 16,
    parameter int CLR_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         cnt_rst_n,
    output logic         cnt_en,
    input  logic [N-1:0] count_in,
    output logic [N-1:0] result,
    output logic         overflow,
    output logic         result_valid,
    input  logic         result_ready,
    output logic         busy
);

    localparam int CLR_W = $clog2(CLR_CYCLES + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [CLR_W-1:0]  CLR_LAST  = CLR_W'(CLR_CYCLES - 1);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_GATE,
        S_SETTLE,
        S_SAMPLE,
        S_HOLD
    } state_t;

    state_t              state_q;
    logic [CLR_W-1:0]    clr_tmr_q;
    logic [GATE_W-1:0]   gate_tmr_q;
    logic [SET_W-1:0]    set_tmr_q;
    logic                cnt_rst_n_q;
    logic                cnt_en_q;
    logic [N-1:0]        result_q;
    logic                overflow_q;
    logic                valid_q;
    logic                busy_q;
    logic                msb_prev_q;
    logic [N-1:0]        s0_q;
    logic [N-1:0]        s1_q;
    logic                s1_full_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            clr_tmr_q   <= '0;
            gate_tmr_q  <= '0;
            set_tmr_q   <= '0;
            cnt_rst_n_q <= 1'b0;
            cnt_en_q    <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            msb_prev_q  <= 1'b0;
            s0_q        <= '0;
            s1_q        <= '0;
            s1_full_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_rst_n_q <= 1'b1;
                    cnt_en_q    <= 1'b0;
                    if (start) begin
                        state_q     <= S_CLEAR;
                        cnt_rst_n_q <= 1'b0;
                        clr_tmr_q   <= '0;
                        overflow_q  <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (clr_tmr_q == CLR_LAST) begin
                        state_q     <= S_GATE;
                        cnt_rst_n_q <= 1'b1;
                        cnt_en_q    <= 1'b1;
                        gate_tmr_q  <= '0;
                        msb_prev_q  <= 1'b0;
                    end else begin
                        clr_tmr_q <= clr_tmr_q + 1'b1;
                    end
                end
                S_GATE: begin
                    // A 1->0 transition of the MSB can only come from a wrap.
                    msb_prev_q <= count_in[N-1];
                    if (msb_prev_q && !count_in[N-1]) begin
                        overflow_q <= 1'b1;
                    end
                    if (gate_tmr_q == GATE_LAST) begin
                        state_q   <= S_SETTLE;
                        cnt_en_q  <= 1'b0;
                        set_tmr_q <= '0;
                    end else begin
                        gate_tmr_q <= gate_tmr_q + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (set_tmr_q == SET_LAST) begin
                        state_q   <= S_SAMPLE;
                        s0_q      <= count_in;
                        s1_full_q <= 1'b0;
                    end else begin
                        set_tmr_q <= set_tmr_q + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    if (!s1_full_q) begin
                        s1_q      <= count_in;
                        s1_full_q <= 1'b1;
                    end else if (s0_q == s1_q) begin
                        state_q  <= S_HOLD;
                        result_q <= s1_q;
                        valid_q  <= 1'b1;
                    end else begin
                        s0_q <= s1_q;
                        s1_q <= count_in;
                    end
                end
                S_HOLD: begin
                    if (result_ready) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign cnt_rst_n    = cnt_rst_n_q;
    assign cnt_en       = cnt_en_q;
    assign result       = result_q;
    assign overflow     = overflow_q;
    assign result_valid = valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_ro_count_reader.sv
// Bench for ro_count_reader: a behavioural edge counter feeds the DUT and each
// measurement is predicted from the preload value and the gate length.
module tb_ro_count_reader;

    localparam int N    = 16;
    localparam int GATE = 10;
    localparam int CLR  = 2;
    localparam int SET  = 4;
    localparam int LAT  = CLR + GATE + SET + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          cnt_rst_n;
    logic          cnt_en;
    logic [N-1:0]  count_in;
    logic [N-1:0]  result;
    logic          overflow;
    logic          result_valid;
    logic          result_ready;
    logic          busy;

    int n_chk  = 0;
    int n_fail = 0;

    logic [N-1:0] cnt;
    logic [N-1:0] preload = '0;
    logic         frc_en  = 1'b0;
    logic [N-1:0] frc_val = '0;

    always #5 clk = ~clk;

    // Edge counter with async clear; the clear loads a chosen start value.
    always @(posedge clk or negedge cnt_rst_n) begin
        if (!cnt_rst_n) cnt <= preload;
        else if (cnt_en) cnt <= cnt + 1'b1;
    end

    assign count_in = frc_en ? frc_val : cnt;

    ro_count_reader #(
        .N(N), .GATE_CYCLES(GATE), .GATE_W(16), .CLR_CYCLES(CLR), .SETTLE_CYCLES(SET)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cnt_rst_n(cnt_rst_n), .cnt_en(cnt_en),
        .count_in(count_in), .result(result), .overflow(overflow),
        .result_valid(result_valid), .result_ready(result_ready), .busy(busy)
    );

    // Pulses start and follows the measurement until result_valid (bounded).
    task automatic run_meas(input int repulse_at, input bit unstable,
                            output int lat, output int clr_n, output int en_n);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0; clr_n = 0; en_n = 0;
        while (result_valid !== 1'b1 && lat < 200) begin
            if (cnt_rst_n === 1'b0) clr_n++;
            if (cnt_en === 1'b1) en_n++;
            start = (lat == repulse_at);
            if (unstable) begin
                frc_en  = (lat >= LAT - 3);
                frc_val = (lat == LAT - 3 || lat == LAT - 1) ? 16'h0005 : 16'h0006;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; result_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (cnt_rst_n !== 1'b0 || cnt_en !== 1'b0 || result !== '0 || result_valid !== 1'b0 ||
            busy !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: got rst_n=%b en=%b res=%h vld=%b busy=%b ovf=%b, want 0 0 0000 0 0 0",
                     cnt_rst_n, cnt_en, result, result_valid, busy, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_chk++;
        if (cnt_rst_n !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_hold: cnt_rst_n=%b want 0", cnt_rst_n);
        end
        @(posedge clk);
        #1;
        n_chk++;
        if (cnt_rst_n !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_edge: cnt_rst_n=%b busy=%b want 1 0", cnt_rst_n, busy);
        end
    endtask

    task automatic test_nominal;
        int lat, clr_n, en_n;
        preload = '0;
        result_ready = 1'b1;
        run_meas(-1, 1'b0, lat, clr_n, en_n);
        n_chk++;
        if (lat !== LAT) begin
            n_fail++; $display("FAIL nominal_latency: got %0d want %0d", lat, LAT);
        end
        n_chk++;
        if (clr_n !== CLR || en_n !== GATE) begin
            n_fail++; $display("FAIL nominal_windows: clr %0d en %0d want %0d %0d", clr_n, en_n, CLR, GATE);
        end
        n_chk++;
        if (result !== 16'd10 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL nominal_result: got %h ovf=%b want 000a 0", result, overflow);
        end
        @(posedge clk);
        #1;
        n_chk++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL nominal_pulse: vld=%b busy=%b want 0 0", result_valid, busy);
        end
    endtask

    task automatic test_random;
        int lat, clr_n, en_n;
        logic [N-1:0] exp_res;
        logic         exp_ovf;
        result_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            preload = (i % 2 == 1) ? 16'(16'hFFF0 + $urandom_range(0, 15)) : 16'($urandom);
            exp_res = 16'((int'(preload) + GATE) % 65536);
            exp_ovf = (int'(preload) + GATE - 1) > 65535;
            run_meas(-1, 1'b0, lat, clr_n, en_n);
            n_chk++;
            if (lat !== LAT || result !== exp_res || overflow !== exp_ovf) begin
                n_fail++;
                $display("FAIL random_meas[%0d]: preload %h got lat %0d res %h ovf %b want %0d %h %b",
                         i, preload, lat, result, overflow, LAT, exp_res, exp_ovf);
            end
            @(posedge clk);
        end
    endtask

    task automatic test_boundaries;
        int lat, clr_n, en_n;
        result_ready = 1'b1;
        preload = 16'hFFFE;
        run_meas(-1, 1'b0, lat, clr_n, en_n);
        n_chk++;
        if (result !== 16'h0008 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL overflow_wrap: got %h ovf=%b want 0008 1", result, overflow);
        end
        @(posedge clk);
        preload = 16'hFFF5;
        run_meas(-1, 1'b0, lat, clr_n, en_n);
        n_chk++;
        if (result !== 16'hFFFF || overflow !== 1'b0) begin
            n_fail++; $display("FAIL all_ones_no_wrap: got %h ovf=%b want ffff 0", result, overflow);
        end
        // Start raised in the handshake cycle must be dropped.
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_chk++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL hold_start_handshake: vld=%b busy=%b want 0 0", result_valid, busy);
        end
        @(posedge clk);
        #1;
        n_chk++;
        if (busy !== 1'b0 || cnt_rst_n !== 1'b1 || result !== 16'hFFFF) begin
            n_fail++; $display("FAIL hold_start_ignored: busy=%b rst_n=%b res=%h want 0 1 ffff",
                               busy, cnt_rst_n, result);
        end
    endtask

    task automatic test_back_pressure;
        int lat, clr_n, en_n;
        int bad;
        preload = 16'h1234;
        result_ready = 1'b0;
        run_meas(-1, 1'b0, lat, clr_n, en_n);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (result_valid !== 1'b1 || result !== 16'h123E) bad++;
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++; $display("FAIL backpressure_hold: %0d bad cycles, last vld=%b res=%h want 1 123e",
                               bad, result_valid, result);
        end
        @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || result !== 16'h123E) begin
            n_fail++; $display("FAIL backpressure_release: vld=%b busy=%b res=%h want 0 0 123e",
                               result_valid, busy, result);
        end
    endtask

    task automatic test_unstable;
        int lat, clr_n, en_n;
        preload = 16'h0000;
        result_ready = 1'b1;
        run_meas(-1, 1'b1, lat, clr_n, en_n);
        frc_en = 1'b0;
        n_chk++;
        if (result !== 16'h0006 || lat < LAT + 3 || lat >= 200) begin
            n_fail++; $display("FAIL unstable_sample: got res %h lat %0d want 0006 lat>=%0d",
                               result, lat, LAT + 3);
        end
        @(posedge clk);
    endtask

    task automatic test_reset_mid_gate;
        int lat, clr_n, en_n;
        preload = 16'h0000;
        result_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (CLR + 3) @(posedge clk);
        #1;
        n_chk++;
        if (cnt_en !== 1'b1) begin
            n_fail++; $display("FAIL mid_gate_entry: cnt_en=%b want 1", cnt_en);
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (cnt_en !== 1'b0 || cnt_rst_n !== 1'b0 || busy !== 1'b0 || result !== '0 ||
            result_valid !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL mid_gate_reset: en=%b rst_n=%b busy=%b res=%h vld=%b ovf=%b want 0 0 0 0000 0 0",
                               cnt_en, cnt_rst_n, busy, result, result_valid, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        run_meas(CLR + 2, 1'b0, lat, clr_n, en_n);
        n_chk++;
        if (lat !== LAT || clr_n !== CLR || en_n !== GATE || result !== 16'd10) begin
            n_fail++; $display("FAIL restart_repulse: lat %0d clr %0d en %0d res %h want %0d %0d %0d 000a",
                               lat, clr_n, en_n, result, LAT, CLR, GATE);
        end
        @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_random();
        test_boundaries();
        test_back_pressure();
        test_unstable();
        test_reset_mid_gate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
